// File: rtl/cache_data_mem_fill.sv
// Cache data array with byte-strobed single-word writes and a critical-word-first
// line refill engine that wraps within the latched line.
module cache_data_mem_fill #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 128,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   address,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [WIDTH/8-1:0] byte_en,
    input  logic               we,
    input  logic               fill_start,
    input  logic               fill_valid,
    input  logic [WIDTH-1:0]   fill_data,
    output logic [WIDTH-1:0]   data_out,
    output logic               rd_valid,
    output logic               busy,
    output logic               fill_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int BYTES = WIDTH / 8;
    localparam logic [IDX_W-1:0] OFF_MASK  = IDX_W'(LINE_WORDS - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  line_base;
    logic [OFF_W-1:0]  offset;
    logic [IDX_W-1:0]  fill_base;
    logic [OFF_W-1:0]  start_off;
    logic [OFF_W-1:0]  beat;
    logic [OFF_W-1:0]  fill_off;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [WIDTH-1:0]  wr_data;
    logic [BYTES-1:0]  wr_mask;

    assign index     = address[IDX_W-1:0];
    assign offset    = index[OFF_W-1:0];
    assign line_base = index & ~OFF_MASK;

    // Offset arithmetic is OFF_W bits wide, so it wraps inside the line for free.
    assign fill_off  = start_off + beat;

    generate
        if (WIDTH > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[WIDTH-1:IDX_W];
        end
    endgenerate

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = index;
        wr_data = data_in;
        wr_mask = byte_en;
        if (state == IDLE) begin
            wr_en = we && !fill_start;
        end else if (fill_valid) begin
            wr_en   = 1'b1;
            wr_idx  = fill_base | IDX_W'(fill_off);
            wr_data = fill_data;
            wr_mask = '1;
        end
    end

    // Storage is deliberately not reset so an aborted refill keeps what it wrote.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fill_base <= '0;
            start_off <= '0;
            beat      <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        fill_base <= line_base;
                        start_off <= offset;
                        beat      <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        if (beat == LAST_BEAT) begin
                            beat      <= '0;
                            fill_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            beat <= beat + OFF_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == FILL);
    assign rd_valid = !busy;
    assign data_out = mem[index];

endmodule

// File: tb/tb_cache_data_mem_fill.sv
// Randomized self-checking bench for cache_data_mem_fill against an array-based
// reference model of the data store and line refill rules.
module tb_cache_data_mem_fill;

    localparam int WIDTH = 32;
    localparam int DEPTH = 128;
    localparam int LW    = 4;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  address;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH/8-1:0] byte_en;
    logic              we;
    logic              fill_start;
    logic              fill_valid;
    logic [WIDTH-1:0]  fill_data;
    logic [WIDTH-1:0]  data_out;
    logic              rd_valid;
    logic              busy;
    logic              fill_done;

    int checks;
    int failures;
    logic [31:0] ref_mem [DEPTH];

    cache_data_mem_fill #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LINE_WORDS(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data_in    (data_in),
        .byte_en    (byte_en),
        .we         (we),
        .fill_start (fill_start),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .fill_done  (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyIdle();
        we         = 1'b0;
        fill_start = 1'b0;
        fill_valid = 1'b0;
    endtask

    task automatic readCheck(input int idx, input string tag);
        @(negedge clk);
        applyIdle();
        address = 32'(idx) + 32'(($urandom % 4) * DEPTH);
        #1;
        checkOutput(tag, data_out, ref_mem[idx]);
    endtask

    task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        int idx;
        @(negedge clk);
        address    = addr;
        data_in    = data;
        byte_en    = be;
        we         = 1'b1;
        fill_start = 1'b0;
        fill_valid = 1'($urandom % 2);
        fill_data  = $urandom;
        @(posedge clk);
        #1;
        idx = int'(addr % DEPTH);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
        checkOutput("wr_word", data_out, ref_mem[idx]);
        checkOutput("wr_busy", busy, 1'b0);
        @(negedge clk);
        applyIdle();
    endtask

    // Critical-word-first refill; gap cycles inserted before beat gap_at,
    // optional ignored requests during stalls, optional reset after abort_after beats.
    task automatic applyFill(input logic [31:0] addr,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3,
                             input int gap_at, input int gap_len,
                             input bit noise, input logic [31:0] na0, input logic [31:0] na1,
                             input int abort_after);
        logic [31:0] beats [4];
        int base;
        int so;
        int tgt;
        beats[0] = d0; beats[1] = d1; beats[2] = d2; beats[3] = d3;
        base = int'(addr % DEPTH) - int'(addr % LW);
        so   = int'(addr % LW);

        @(negedge clk);
        address    = addr;
        fill_start = 1'b1;
        we         = noise;
        data_in    = $urandom;
        byte_en    = '1;
        fill_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("fill_busy_start", busy, 1'b1);
        checkOutput("fill_rdv_start", rd_valid, 1'b0);

        for (int k = 0; k < LW; k++) begin
            tgt = base + ((so + k) % LW);
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    fill_valid = 1'b0;
                    fill_data  = $urandom;
                    if (noise) begin
                        we         = 1'b1;
                        fill_start = 1'b1;
                        address    = (g % 2 == 0) ? na0 : na1;
                        data_in    = $urandom;
                        byte_en    = '1;
                    end else begin
                        we         = 1'b0;
                        fill_start = 1'b0;
                        address    = 32'(tgt);
                    end
                    @(posedge clk);
                    #1;
                    checkOutput("stall_busy", busy, 1'b1);
                    checkOutput("stall_done", fill_done, 1'b0);
                    checkOutput("stall_nowrite", data_out, ref_mem[int'(address % DEPTH)]);
                end
            end
            @(negedge clk);
            fill_valid = 1'b1;
            fill_data  = beats[k];
            we         = noise;
            fill_start = noise;
            data_in    = $urandom;
            address    = 32'(tgt);
            @(posedge clk);
            #1;
            ref_mem[tgt] = beats[k];
            checkOutput("beat_data", data_out, beats[k]);
            if (k < LW - 1) begin
                checkOutput("beat_busy", busy, 1'b1);
                checkOutput("beat_done", fill_done, 1'b0);
            end else begin
                checkOutput("last_busy", busy, 1'b0);
                checkOutput("last_done", fill_done, 1'b1);
                checkOutput("last_rdv", rd_valid, 1'b1);
            end
            if (abort_after == k + 1 && k < LW - 1) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("abort_busy", busy, 1'b0);
                checkOutput("abort_done", fill_done, 1'b0);
                checkOutput("abort_rdv", rd_valid, 1'b1);
                @(negedge clk);
                applyIdle();
                @(posedge clk);
                #1;
                checkOutput("abort_hold_done", fill_done, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("abort_post_done", fill_done, 1'b0);
                checkOutput("abort_post_busy", busy, 1'b0);
                return;
            end
        end
        @(negedge clk);
        applyIdle();
        @(posedge clk);
        #1;
        checkOutput("done_pulse_end", fill_done, 1'b0);
        checkOutput("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int op;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        address    = '0;
        data_in    = '0;
        byte_en    = '0;
        fill_data  = '0;
        applyIdle();
        #3;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", fill_done, 1'b0);
        checkOutput("reset_rdv", rd_valid, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) applyWrite(32'(i), $urandom, 4'hF);

        // Byte-strobed write through an aliased address
        applyWrite(32'd5, 32'h11223344, 4'hF);
        applyWrite(32'h85, 32'hAABBCCDD, 4'b0011);
        checkOutput("byte_write_alias", data_out, 32'h1122CCDD);
        applyWrite(32'd5, 32'h55667788, 4'b0000);
        checkOutput("byte_en_zero", data_out, 32'h1122CCDD);

        // Back-to-back critical-word-first fill
        applyFill(32'd14, 32'hD0, 32'hD1, 32'hD2, 32'hD3, -1, 0, 1'b0, 32'd0, 32'd0, 0);
        readCheck(14, "cwf_14"); checkOutput("cwf_14_const", data_out, 32'hD0);
        readCheck(15, "cwf_15"); checkOutput("cwf_15_const", data_out, 32'hD1);
        readCheck(12, "cwf_12"); checkOutput("cwf_12_const", data_out, 32'hD2);
        readCheck(13, "cwf_13"); checkOutput("cwf_13_const", data_out, 32'hD3);

        // Stalled fill over a scrambled line
        for (int i = 12; i < 16; i++) applyWrite(32'(i), 32'hEE000000 + 32'(i), 4'hF);
        applyFill(32'd14, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 2, 3, 1'b0, 32'd0, 32'd0, 0);
        readCheck(12, "stall_12"); checkOutput("stall_12_const", data_out, 32'hD2);
        readCheck(15, "stall_15"); checkOutput("stall_15_const", data_out, 32'hD1);

        // Requests during FILL must be ignored
        applyFill(32'd14, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1, 4, 1'b1, 32'd3, 32'd40, 0);
        readCheck(3, "ign_3");
        for (int i = 40; i < 44; i++) readCheck(i, "ign_line40");
        readCheck(14, "ign_14"); checkOutput("ign_14_const", data_out, 32'hA0);

        // Reset after two beats
        applyWrite(32'd12, 32'h12121212, 4'hF);
        applyWrite(32'd13, 32'h13131313, 4'hF);
        applyFill(32'd14, 32'hD0, 32'hD1, 32'hD2, 32'hD3, -1, 0, 1'b0, 32'd0, 32'd0, 2);
        readCheck(14, "abort_14"); checkOutput("abort_14_const", data_out, 32'hD0);
        readCheck(15, "abort_15"); checkOutput("abort_15_const", data_out, 32'hD1);
        readCheck(12, "abort_12"); checkOutput("abort_12_const", data_out, 32'h12121212);
        readCheck(13, "abort_13"); checkOutput("abort_13_const", data_out, 32'h13131313);
        applyFill(32'd0, 32'hB0, 32'hB1, 32'hB2, 32'hB3, -1, 0, 1'b0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 4; i++) readCheck(i, "post_abort_fill");

        // Randomized mix of writes, fills, stalls, ignored requests and aborts
        for (int it = 0; it < 200; it++) begin
            op = int'($urandom % 10);
            if (op < 5) begin
                applyWrite($urandom, $urandom, 4'($urandom));
            end else begin
                applyFill($urandom, $urandom, $urandom, $urandom, $urandom,
                          int'($urandom % 4), int'($urandom % 4), 1'($urandom % 2),
                          $urandom, $urandom,
                          (op == 9) ? int'($urandom_range(1, 3)) : 0);
            end
        end

        for (int i = 0; i < DEPTH; i++) readCheck(i, "final_mem");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
